// File: rtl/seg7_scan_drv_if.sv
// Digit bus between the display managers (producers) and the scan driver
// (consumer). Each digit is {en, hex[3:0], dp}; d1 is the rightmost digit.
interface seg7_scan_drv_if;
  logic [5:0] d1;
  logic [5:0] d2;
  logic [5:0] d3;
  logic [5:0] d4;
  logic [5:0] d5;
  logic [5:0] d6;
  logic [5:0] d7;
  logic [5:0] d8;

  modport master (output d1, d2, d3, d4, d5, d6, d7, d8);
  modport slave  (input  d1, d2, d3, d4, d5, d6, d7, d8);
endinterface

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed scan driver for an eight-digit common-anode 7-segment
// display. Each slot lasts REFRESH_CNT cycles and opens with BLANK_CYC cycles
// of all anodes off, which hides ghosting while the cathodes change. The
// digit is captured during the blank window and held for the rest of the
// slot, so bus changes mid-slot show up only on the next visit.
// All outputs are registered, one cycle behind (cnt, idx, cap).
module seg7_scan_drv #(
  parameter int REFRESH_CNT = 100000,
  parameter int BLANK_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_drv_if.slave    digits,
  output logic [7:0]        an,
  output logic [7:0]        dec_cat,
  output logic              slot_strobe
);

  localparam int CW = $clog2(REFRESH_CNT);
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_CNT - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [5:0]    r_cap;
  logic [7:0]    r_an;
  logic [7:0]    r_cat;
  logic          r_strobe;

  logic          w_tc;
  logic          w_blank;
  logic [5:0]    w_sel;
  logic [6:0]    w_seg;

  // Lit segments {a,b,c,d,e,f,g} for a hex nibble (1 = segment on).
  function automatic logic [6:0] seg_lit(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign w_tc    = (r_cnt == CNT_MAX);
  assign w_blank = (r_cnt < BLANK_END);
  assign w_seg   = seg_lit(r_cap[4:1]);

  // Select the bus digit belonging to the current slot.
  always_comb begin
    w_sel = 6'b0;
    case (r_idx)
      3'd0: w_sel = digits.d1;
      3'd1: w_sel = digits.d2;
      3'd2: w_sel = digits.d3;
      3'd3: w_sel = digits.d4;
      3'd4: w_sel = digits.d5;
      3'd5: w_sel = digits.d6;
      3'd6: w_sel = digits.d7;
      default: w_sel = digits.d8;
    endcase
  end

  // Slot timer and slot index; idx advances on the last cycle of a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Capture the active digit throughout the blank window, hold it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap <= 6'b0;
    end else if (w_blank) begin
      r_cap <= w_sel;
    end
  end

  // Registered drive: blank or disabled slots keep everything dark but still
  // take their full slot time so brightness stays uniform across digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an     <= 8'hFF;
      r_cat    <= 8'hFF;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_tc;
      if (w_blank || !r_cap[5]) begin
        r_an  <= 8'hFF;
        r_cat <= 8'hFF;
      end else begin
        r_an  <= ~(8'b1 << r_idx);
        r_cat <= {~w_seg, ~r_cap[0]};
      end
    end
  end

  assign an          = r_an;
  assign dec_cat     = r_cat;
  assign slot_strobe = r_strobe;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv with REFRESH_CNT=8, BLANK_CYC=2.
// n counts clock edges after reset release; the outputs seen after edge n
// reflect slot (n/8)%8, phase n%8, lit when phase >= 2.
module tb_seg7_scan_drv;
  localparam int RC = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] an;
  logic [7:0] dec_cat;
  logic       slot_strobe;

  seg7_scan_drv_if u_if ();

  seg7_scan_drv #(.REFRESH_CNT(RC), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst         (rst),
    .digits      (u_if.slave),
    .an          (an),
    .dec_cat     (dec_cat),
    .slot_strobe (slot_strobe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Hand-derived cathode bytes for hex 0..F with dp off (bit0 = 1).
  logic [7:0] cat_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  logic       m_en  [8];
  logic [3:0] m_hex [8];
  logic       m_dp  [8];

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic set_digit(input int k, input logic en, input logic [3:0] h, input logic dp);
    logic [5:0] v;
    v = {en, h, dp};
    m_en[k]  = en;
    m_hex[k] = h;
    m_dp[k]  = dp;
    case (k)
      0: u_if.d1 = v;
      1: u_if.d2 = v;
      2: u_if.d3 = v;
      3: u_if.d4 = v;
      4: u_if.d5 = v;
      5: u_if.d6 = v;
      6: u_if.d7 = v;
      default: u_if.d8 = v;
    endcase
  endtask

  task automatic load_frame();
    for (int k = 0; k < 8; k++) set_digit(k, 1'b1, 4'(k), 1'b0);
  endtask

  function automatic logic [7:0] mdl_an(input int c);
    int s;
    int ph;
    logic [7:0] v;
    s  = (c / RC) % 8;
    ph = c % RC;
    v  = 8'h01 << s;
    if (ph >= BC && m_en[s]) return ~v;
    return 8'hFF;
  endfunction

  function automatic logic [7:0] mdl_cat(input int c);
    int s;
    int ph;
    logic [7:0] v;
    s  = (c / RC) % 8;
    ph = c % RC;
    if (!(ph >= BC && m_en[s])) return 8'hFF;
    v = cat_tab[m_hex[s]];
    if (m_dp[s]) v[0] = 1'b0;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    n = -1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    load_frame();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (an !== 8'hFF || dec_cat !== 8'hFF || slot_strobe !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got an=%h cat=%h stb=%b exp an=ff cat=ff stb=0",
                 i, an, dec_cat, slot_strobe);
      end
    end
    rst = 1'b0;
    n = -1;
    for (int i = 0; i < 3; i++) begin
      step();
      e = (i < 2) ? 8'hFF : 8'hFE;
      total++;
      if (an !== e) begin
        bad++;
        $display("FAIL reset_release n=%0d got an=%h exp %h", n, an, e);
      end
    end
  endtask

  task automatic test_full_frame();
    int stb;
    stb = 0;
    load_frame();
    do_reset();
    for (int i = 0; i < 72; i++) begin
      step();
      if (slot_strobe === 1'b1) stb++;
      total++;
      if (an !== mdl_an(n) || dec_cat !== mdl_cat(n) || slot_strobe !== ((n % RC) == RC - 1)) begin
        bad++;
        $display("FAIL frame n=%0d got an=%h cat=%h stb=%b exp an=%h cat=%h stb=%b",
                 n, an, dec_cat, slot_strobe, mdl_an(n), mdl_cat(n), (n % RC) == RC - 1);
      end
    end
    total++;
    if (stb != 9) begin
      bad++;
      $display("FAIL strobe_count got %0d exp 9", stb);
    end
  endtask

  task automatic test_hex_all();
    logic [7:0] e;
    load_frame();
    for (int h = 0; h < 16; h++) begin
      set_digit(0, 1'b1, 4'(h), 1'b1);
      do_reset();
      repeat (3) step();
      e = cat_tab[h] & 8'hFE;
      total++;
      if (an !== 8'hFE || dec_cat !== e) begin
        bad++;
        $display("FAIL hex_%0h got an=%h cat=%h exp an=fe cat=%h", h, an, dec_cat, e);
      end
    end
  endtask

  task automatic test_disabled();
    load_frame();
    set_digit(4, 1'b0, 4'h0, 1'b0);
    set_digit(6, 1'b0, 4'h0, 1'b0);
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step();
      total++;
      if (an !== mdl_an(n) || dec_cat !== mdl_cat(n)) begin
        bad++;
        $display("FAIL disabled n=%0d got an=%h cat=%h exp an=%h cat=%h",
                 n, an, dec_cat, mdl_an(n), mdl_cat(n));
      end
    end
  endtask

  task automatic test_mid_slot();
    load_frame();
    set_digit(1, 1'b1, 4'h3, 1'b0);
    do_reset();
    for (int i = 0; i < 80; i++) begin
      step();
      total++;
      if (an !== mdl_an(n) || dec_cat !== mdl_cat(n)) begin
        bad++;
        $display("FAIL mid_slot n=%0d got an=%h cat=%h exp an=%h cat=%h",
                 n, an, dec_cat, mdl_an(n), mdl_cat(n));
      end
      if (n == 11) begin
        set_digit(1, 1'b1, 4'h9, 1'b0);
        m_hex[1] = 4'h3;
      end
      if (n == 15) m_hex[1] = 4'h9;
    end
    total++;
    if (m_hex[1] != 4'h9 || dec_cat === 8'h0D) begin
      bad++;
      $display("FAIL mid_slot_final got cat=%h exp not 0d", dec_cat);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    load_frame();
    do_reset();
    while (n < 43) step();
    total++;
    if (an !== 8'hDF || dec_cat !== cat_tab[5]) begin
      bad++;
      $display("FAIL pre_reset got an=%h cat=%h exp an=df cat=%h", an, dec_cat, cat_tab[5]);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (an !== 8'hFF || dec_cat !== 8'hFF || slot_strobe !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got an=%h cat=%h stb=%b exp an=ff cat=ff stb=0",
                 i, an, dec_cat, slot_strobe);
      end
    end
    rst = 1'b0;
    n = -1;
    for (int i = 0; i < 3; i++) begin
      step();
      e = (i < 2) ? 8'hFF : 8'hFE;
      total++;
      if (an !== e || dec_cat !== ((i < 2) ? 8'hFF : 8'h03)) begin
        bad++;
        $display("FAIL restart n=%0d got an=%h cat=%h exp an=%h", n, an, dec_cat, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_hex_all();
    test_disabled();
    test_mid_slot();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
